palette_colorizer: RTL
======================

PALETTE_COLORIZER -- requirements
Module: palette_colorizer

Interface
REQ-001 Parameter COLOR_W, default 12: pixel color width; SHALL be a multiple of 3; R/G/B each COLOR_W/3 bits.
REQ-002 Parameter WORLD_W, default 2: world-pixel code width; palette depth 2**WORLD_W.
REQ-003 Parameter N_ICON, default 2: number of icon layers; layer 0 has highest priority.
REQ-004 Parameter BLINK_FRAMES, default 30: frames per blink half-period; legal range 1..255.
REQ-005 clk  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-006 reset_n  in  1  reset; asynchronous, active-low.
REQ-007 world_pixel  in  WORLD_W  world map code for the current pixel.
REQ-008 icon  in  N_ICON*COLOR_W  icon colors; layer k occupies bits [k*COLOR_W +: COLOR_W]; all-zero means transparent.
REQ-009 video_on  in  1  active display area.
REQ-010 hsync_in, vsync_in  in  1 each  sync from the timing generator.
REQ-011 pal_we  in  1  palette write request, single-cycle pulse.
REQ-012 pal_addr  in  WORLD_W  palette entry to write.
REQ-013 pal_data  in  COLOR_W  new palette color.
REQ-014 pal_busy  out  1  write pending, not yet committed.
REQ-015 pal_ack  out  1  one-cycle pulse on commit.
REQ-016 VGA_R, VGA_G, VGA_B  out  COLOR_W/3 each  pixel color.
REQ-017 hsync_out, vsync_out  out  1 each  syncs aligned to the pixel color.

Function
REQ-018 Fixed two-cycle pipeline: inputs sampled at edge N SHALL appear on VGA_*/hsync_out/vsync_out after edge N+2.
REQ-019 Stage 1 registers: palette color for world_pixel, all icon layers, video_on, hsync_in, vsync_in.
REQ-020 Stage 2 output: if the registered video_on is 0, color 0; else the lowest-index non-transparent icon layer; else the palette color.
REQ-021 Palette reset contents: entry 0 = all ones (white); entry 1 = 0 (black); entry 2 = top COLOR_W/3 bits set (red); every other entry = 0.
REQ-022 Write FSM states:
- IDLE -> PENDING on pal_we: latch pal_addr and pal_data; pal_busy = 1 from the next cycle.
- PENDING -> COMMIT on the first cycle with video_on = 0 (raw input); the write is applied on that edge.
- COMMIT -> IDLE after one cycle, with pal_ack = 1 for exactly that cycle.
REQ-023 If pal_we arrives while video_on = 0 in IDLE, the FSM SHALL still pass through PENDING; the commit occurs one cycle later.
REQ-024 pal_we in PENDING or COMMIT SHALL be ignored; the latched write is unchanged and no second ack is generated.
REQ-025 A stage-1 lookup on the same edge as a commit SHALL return the old entry value.
REQ-026 Only palette entries change on a write; pipeline contents are never flushed.

Reset
REQ-027 While reset_n = 0: VGA_* = 0, hsync_out = hsync_out reset level 1, vsync_out = 1, pal_busy = 0, pal_ack = 0, FSM = IDLE, palette at reset contents, all pipeline registers cleared (syncs to 1, video_on to 0).
REQ-028 Reset asserted while in PENDING SHALL discard the latched write; no ack SHALL be generated.
REQ-029 After deassertion, outputs SHALL be valid from the third rising edge.

Configuration
REQ-030 With macro COLORIZER_BLINK_EN defined:
- An 8-bit frame counter increments on each registered vsync_in falling edge and wraps from BLINK_FRAMES-1 to 0.
- On each wrap a phase bit toggles.
- While the phase bit = 1, icon layer 0 is treated as transparent.
- The counter and phase bit reset to 0.
REQ-031 Without COLORIZER_BLINK_EN: no counter and no phase bit are synthesised, and layer 0 is never suppressed.

Verification
REQ-032 Reset release, world_pixel=2, video_on=1, icon=0 -> third edge: {R,G,B}=12'hF00; hsync/vsync delayed by exactly 2 cycles.
REQ-033 icon layer0=0, layer1=12'h0A5, video_on=1 -> output 12'h0A5; then layer0=12'h123 -> output 12'h123; then video_on=0 -> output 12'h000.
REQ-034 pal_we with addr=1, data=12'h0F0, while video_on=1 for 10 cycles -> pal_busy=1 and entry 1 still reads 12'h000 throughout; video_on falls -> pal_ack pulses once; world_pixel=1 then outputs 12'h0F0.
REQ-035 Second pal_we (addr=0, data=12'h00F) during PENDING -> ignored: entry 0 stays 12'hFFF, exactly one ack.
REQ-036 reset_n pulsed low during PENDING -> palette unchanged, pal_ack never asserted.
REQ-037 COLORIZER_BLINK_EN defined, BLINK_FRAMES=2, layer0=12'h111 constant -> layer 0 shown for 2 frames, suppressed for 2 frames, repeating; with the macro undefined -> always shown.

Source files
------------

// File: rtl/palette_colorizer.sv
// Palette/icon colorizer: two-stage pixel pipeline with a blanking-deferred palette write port.
// Optional icon-layer-0 blinking is enabled by defining COLORIZER_BLINK_EN.
module palette_colorizer #(
  parameter int COLOR_W      = 12,
  parameter int WORLD_W      = 2,
  parameter int N_ICON       = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WORLD_W-1:0]        world_pixel,
  input  logic [N_ICON*COLOR_W-1:0] icon,
  input  logic                      video_on,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      pal_we,
  input  logic [WORLD_W-1:0]        pal_addr,
  input  logic [COLOR_W-1:0]        pal_data,
  output logic                      pal_busy,
  output logic                      pal_ack,
  output logic [COLOR_W/3-1:0]      VGA_R,
  output logic [COLOR_W/3-1:0]      VGA_G,
  output logic [COLOR_W/3-1:0]      VGA_B,
  output logic                      hsync_out,
  output logic                      vsync_out
);

  localparam int CW    = COLOR_W / 3;
  localparam int DEPTH = 1 << WORLD_W;
  localparam logic [COLOR_W-1:0] RED = {{CW{1'b1}}, {(COLOR_W-CW){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } wr_state_e;

  wr_state_e            state_q, state_d;
  logic [WORLD_W-1:0]   waddr_q;
  logic [COLOR_W-1:0]   wdata_q;
  logic                 latch_en;
  logic                 commit_en;

  logic [COLOR_W-1:0]   pal_q [DEPTH];

  logic [COLOR_W-1:0]        pix_q;
  logic [N_ICON*COLOR_W-1:0] icon_q;
  logic                      video_q;
  logic                      hs_q;
  logic                      vs_q;

  logic [COLOR_W-1:0]   rgb_q, rgb_d;
  logic                 hs_out_q;
  logic                 vs_out_q;
  logic                 suppress0;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        waddr_q <= pal_addr;
        wdata_q <= pal_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    commit_en = 1'b0;
    pal_busy  = 1'b0;
    pal_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pal_we) begin
          latch_en = 1'b1;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        pal_busy = 1'b1;
        if (!video_on) begin
          commit_en = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        pal_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ palette
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 0)      pal_q[i] <= '1;
        else if (i == 2) pal_q[i] <= RED;
        else             pal_q[i] <= '0;
      end
    end else if (commit_en) begin
      pal_q[waddr_q] <= wdata_q;
    end
  end

  // ------------------------------------------------------------------ stage 1
  // The lookup reads pal_q before the commit's NBA lands, so a same-edge read sees the old entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q   <= '0;
      icon_q  <= '0;
      video_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else begin
      pix_q   <= pal_q[world_pixel];
      icon_q  <= icon;
      video_q <= video_on;
      hs_q    <= hsync_in;
      vs_q    <= vsync_in;
    end
  end

  // -------------------------------------------------------------------- blink
`ifdef COLORIZER_BLINK_EN
  logic [7:0] frame_cnt_q;
  logic       phase_q;
  logic       vs_fall;

  // vs_out_q is vs_q delayed one cycle, so this marks a falling edge of the registered vsync.
  assign vs_fall = vs_out_q & ~vs_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (vs_fall) begin
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign suppress0 = phase_q;
`else
  assign suppress0 = 1'b0;
`endif

  // ------------------------------------------------------------------ stage 2
  always_comb begin
    logic found;
    rgb_d = pix_q;
    found = 1'b0;
    for (int unsigned k = 0; k < N_ICON; k++) begin
      if (!found && (icon_q[k*COLOR_W +: COLOR_W] != '0) && !(k == 0 && suppress0)) begin
        rgb_d = icon_q[k*COLOR_W +: COLOR_W];
        found = 1'b1;
      end
    end
    if (!video_q) rgb_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q    <= '0;
      hs_out_q <= 1'b1;
      vs_out_q <= 1'b1;
    end else begin
      rgb_q    <= rgb_d;
      hs_out_q <= hs_q;
      vs_out_q <= vs_q;
    end
  end

  assign VGA_R     = rgb_q[COLOR_W-1 -: CW];
  assign VGA_G     = rgb_q[2*CW-1 -: CW];
  assign VGA_B     = rgb_q[CW-1:0];
  assign hsync_out = hs_out_q;
  assign vsync_out = vs_out_q;

endmodule
